// File: rtl/updown_counter_pkg.sv
// Shared types and default sizes for the parametrised up/down counter core.
package updown_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 4;

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle between the tile wrapper (master) and the counter core (slave).
interface updown_counter_param_if
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
);
    logic              en;
    logic              up;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    mode_e             mode;
    logic              clr_flags;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              unf;

    modport master (
        output en, up, load, load_val, step, limit, mode, clr_flags,
        input  count, tc, ovf, unf
    );

    modport slave (
        input  en, up, load, load_val, step, limit, mode, clr_flags,
        output count, tc, ovf, unf
    );
endinterface

// File: rtl/updown_next_calc.sv
// Combinational next-count for one enabled step: boundary detection, wrap/saturate
// resolution and the overflow/underflow events that feed the sticky flags.
module updown_next_calc
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic [WIDTH-1:0]  i_count,
    input  logic [STEP_W-1:0] i_step,
    input  logic [WIDTH-1:0]  i_limit,
    input  logic              i_up,
    input  mode_e             i_mode,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_tc,
    output logic              o_ovf_evt,
    output logic              o_unf_evt
);

    function automatic logic [WIDTH:0] min_u(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        return (a < b) ? a : b;
    endfunction

    // One spare bit keeps count+s and count+limit+1 from wrapping before compare.
    logic [WIDTH:0] w_cnt_x;
    logic [WIDTH:0] w_lim_x;
    logic [WIDTH:0] w_lim1;
    logic [WIDTH:0] w_s;
    logic [WIDTH:0] w_sum;
    logic           w_oor;

    assign w_cnt_x = {1'b0, i_count};
    assign w_lim_x = {1'b0, i_limit};
    assign w_lim1  = w_lim_x + 1'b1;
    assign w_s     = min_u({{(WIDTH + 1 - STEP_W){1'b0}}, i_step}, w_lim_x);
    assign w_sum   = w_cnt_x + w_s;
    assign w_oor   = (w_cnt_x > w_lim_x);

    always_comb begin
        o_next    = i_count;
        o_tc      = 1'b0;
        o_ovf_evt = 1'b0;
        o_unf_evt = 1'b0;
        if (w_s != '0) begin
            if (w_oor) begin
                // Limit dropped below the count: snap back into range as an overflow.
                o_next    = (i_mode == MODE_SAT) ? i_limit : '0;
                o_tc      = 1'b1;
                o_ovf_evt = 1'b1;
            end else if (i_up) begin
                if (w_sum > w_lim_x) begin
                    o_next    = (i_mode == MODE_SAT) ? i_limit : WIDTH'(w_sum - w_lim1);
                    o_tc      = 1'b1;
                    o_ovf_evt = 1'b1;
                end else begin
                    o_next = WIDTH'(w_sum);
                end
            end else begin
                if (w_s > w_cnt_x) begin
                    o_next    = (i_mode == MODE_SAT) ? '0 : WIDTH'(w_cnt_x + w_lim1 - w_s);
                    o_tc      = 1'b1;
                    o_unf_evt = 1'b1;
                end else begin
                    o_next = WIDTH'(w_cnt_x - w_s);
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter core: registers, rst > load > en priority and
// sticky overflow/underflow flags around the combinational step calculator.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    updown_counter_param_if.slave  bus
);

    function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] v,
                                                        input logic [WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_step_cycle;

    updown_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .i_count   (r_count),
        .i_step    (bus.step),
        .i_limit   (bus.limit),
        .i_up      (bus.up),
        .i_mode    (bus.mode),
        .o_next    (w_next),
        .o_tc      (w_tc),
        .o_ovf_evt (w_ovf_evt),
        .o_unf_evt (w_unf_evt)
    );

    assign w_step_cycle = bus.en && !bus.load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_count <= clamp_to_limit(bus.load_val, bus.limit);
            end else if (bus.en) begin
                r_count <= w_next;
                r_tc    <= w_tc;
            end
            // A flag-setting event in the same cycle overrides the clear.
            if (w_step_cycle && w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_flags) begin
                r_ovf <= 1'b0;
            end
            if (w_step_cycle && w_unf_evt) begin
                r_unf <= 1'b1;
            end else if (bus.clr_flags) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an integer reference model.
module tb_updown_counter_param;
    import updown_counter_pkg::*;

    localparam int W  = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(W), .STEP_W(SW)) u_if ();

    updown_counter_param #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    // Reference model: plain integer arithmetic, modulo for wrap.
    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;
    int m_unf   = 0;

    always @(posedge clk) begin
        int lim, s, ev_o, ev_u;
        if (rst) begin
            m_count = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else begin
            lim  = int'(u_if.limit);
            ev_o = 0;
            ev_u = 0;
            if (u_if.load) begin
                m_count = (int'(u_if.load_val) < lim) ? int'(u_if.load_val) : lim;
            end else if (u_if.en) begin
                s = (int'(u_if.step) < lim) ? int'(u_if.step) : lim;
                if (s > 0) begin
                    if (m_count > lim) begin
                        m_count = (u_if.mode == MODE_SAT) ? lim : 0;
                        ev_o = 1;
                    end else if (u_if.up) begin
                        if (m_count + s > lim) begin
                            m_count = (u_if.mode == MODE_SAT) ? lim : (m_count + s) % (lim + 1);
                            ev_o = 1;
                        end else begin
                            m_count = m_count + s;
                        end
                    end else begin
                        if (s > m_count) begin
                            m_count = (u_if.mode == MODE_SAT) ? 0 : (m_count - s + lim + 1) % (lim + 1);
                            ev_u = 1;
                        end else begin
                            m_count = m_count - s;
                        end
                    end
                end
            end
            m_tc = (ev_o != 0 || ev_u != 0) ? 1 : 0;
            if (u_if.clr_flags) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (ev_o != 0) m_ovf = 1;
            if (ev_u != 0) m_unf = 1;
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if (int'(u_if.count) !== m_count || int'(u_if.tc) !== m_tc ||
            int'(u_if.ovf) !== m_ovf || int'(u_if.unf) !== m_unf) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got count=%0d tc=%0d ovf=%0d unf=%0d expected count=%0d tc=%0d ovf=%0d unf=%0d",
                     $time, u_if.count, u_if.tc, u_if.ovf, u_if.unf, m_count, m_tc, m_ovf, m_unf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_ctl(input bit en, input bit up, input int step, input int limit, input mode_e mode);
        u_if.en    = en;
        u_if.up    = up;
        u_if.step  = SW'(step);
        u_if.limit = W'(limit);
        u_if.mode  = mode;
    endtask

    initial begin
        int tcs;
        int exp_a[5];
        int tc_a[5];

        rst = 1'b1;
        u_if.load = 1'b0; u_if.load_val = '0; u_if.clr_flags = 1'b0;
        set_ctl(1'b0, 1'b1, 1, 255, MODE_WRAP);
        cyc(); cyc();
        chk("reset_count", int'(u_if.count), 0);
        chk("reset_flags", int'({u_if.tc, u_if.ovf, u_if.unf}), 0);

        // Full-range wrap at WIDTH=8.
        rst = 1'b0;
        set_ctl(1'b1, 1'b1, 1, 255, MODE_WRAP);
        tcs = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            tcs += int'(u_if.tc);
            if (i == 255) begin
                chk("full_255", int'(u_if.count), 255);
                chk("full_255_ovf", int'(u_if.ovf), 0);
            end
            if (i == 256) begin
                chk("full_wrap_count", int'(u_if.count), 0);
                chk("full_wrap_tc", int'(u_if.tc), 1);
                chk("full_wrap_ovf", int'(u_if.ovf), 1);
            end
        end
        chk("full_tc_pulses", tcs, 1);

        // limit=9 wrap, up by 3 then down by 4.
        u_if.load = 1'b1; u_if.load_val = '0; u_if.clr_flags = 1'b1;
        set_ctl(1'b0, 1'b1, 3, 9, MODE_WRAP);
        cyc();
        u_if.load = 1'b0; u_if.clr_flags = 1'b0;
        set_ctl(1'b1, 1'b1, 3, 9, MODE_WRAP);
        exp_a = '{3, 6, 9, 2, 5};
        tc_a  = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("wrap9_up_count[%0d]", i), int'(u_if.count), exp_a[i]);
            chk($sformatf("wrap9_up_tc[%0d]", i), int'(u_if.tc), tc_a[i]);
        end
        set_ctl(1'b1, 1'b0, 4, 9, MODE_WRAP);
        cyc();
        chk("wrap9_dn_count0", int'(u_if.count), 1);
        chk("wrap9_dn_tc0", int'(u_if.tc), 0);
        cyc();
        chk("wrap9_dn_count1", int'(u_if.count), 7);
        chk("wrap9_dn_tc1", int'(u_if.tc), 1);
        chk("wrap9_dn_unf", int'(u_if.unf), 1);

        // Saturate at 100 and at 0.
        u_if.load = 1'b1; u_if.load_val = 8'd98; u_if.clr_flags = 1'b1;
        set_ctl(1'b0, 1'b1, 5, 100, MODE_SAT);
        cyc();
        u_if.load = 1'b0; u_if.clr_flags = 1'b0;
        set_ctl(1'b1, 1'b1, 5, 100, MODE_SAT);
        cyc();
        chk("sat_hi_count", int'(u_if.count), 100);
        chk("sat_hi_tc", int'(u_if.tc), 1);
        cyc();
        chk("sat_hi_again_count", int'(u_if.count), 100);
        chk("sat_hi_again_tc", int'(u_if.tc), 1);
        set_ctl(1'b1, 1'b0, 5, 100, MODE_SAT);
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_lo_reach", int'(u_if.count), 0);
        chk("sat_lo_reach_tc", int'(u_if.tc), 0);
        cyc();
        chk("sat_lo_tc1", int'(u_if.tc), 1);
        chk("sat_lo_unf", int'(u_if.unf), 1);
        cyc();
        chk("sat_lo_count2", int'(u_if.count), 0);
        chk("sat_lo_tc2", int'(u_if.tc), 1);

        // Load wins over enable and is clamped to limit.
        u_if.load = 1'b1; u_if.load_val = 8'd200;
        set_ctl(1'b1, 1'b1, 5, 50, MODE_SAT);
        cyc();
        chk("load_clamp_count", int'(u_if.count), 50);
        chk("load_clamp_tc", int'(u_if.tc), 0);

        // Limit reduced below count, then flag clearing.
        u_if.load = 1'b1; u_if.load_val = 8'd80; u_if.clr_flags = 1'b1;
        set_ctl(1'b0, 1'b0, 1, 100, MODE_WRAP);
        cyc();
        u_if.load = 1'b0; u_if.clr_flags = 1'b0;
        set_ctl(1'b1, 1'b0, 1, 40, MODE_WRAP);
        cyc();
        chk("oor_count", int'(u_if.count), 0);
        chk("oor_tc", int'(u_if.tc), 1);
        chk("oor_ovf", int'(u_if.ovf), 1);
        u_if.clr_flags = 1'b1;
        set_ctl(1'b0, 1'b0, 1, 40, MODE_WRAP);
        cyc();
        chk("clr_alone", int'({u_if.ovf, u_if.unf}), 0);
        u_if.clr_flags = 1'b0; u_if.load = 1'b1; u_if.load_val = 8'd40;
        cyc();
        u_if.load = 1'b0; u_if.clr_flags = 1'b1;
        set_ctl(1'b1, 1'b1, 1, 40, MODE_WRAP);
        cyc();
        chk("clr_vs_event_count", int'(u_if.count), 0);
        chk("clr_vs_event_ovf", int'(u_if.ovf), 1);
        u_if.clr_flags = 1'b0;

        // Reset mid-count beats load/en; zero step holds.
        cyc(); cyc();
        rst = 1'b1; u_if.load = 1'b1; u_if.load_val = 8'd7;
        cyc();
        chk("rst_mid_count", int'(u_if.count), 0);
        chk("rst_mid_flags", int'({u_if.tc, u_if.ovf, u_if.unf}), 0);
        rst = 1'b0; u_if.load = 1'b1; u_if.load_val = 8'd5;
        set_ctl(1'b0, 1'b1, 0, 40, MODE_WRAP);
        cyc();
        u_if.load = 1'b0;
        set_ctl(1'b1, 1'b1, 0, 40, MODE_WRAP);
        cyc(); cyc();
        chk("step0_hold", int'(u_if.count), 5);
        chk("step0_tc", int'(u_if.tc), 0);

        // Randomized traffic; model comparison runs every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            u_if.load      = ($urandom_range(0, 19) == 0);
            u_if.load_val  = W'($urandom_range(0, 255));
            u_if.en        = ($urandom_range(0, 9) != 0);
            u_if.up        = 1'($urandom_range(0, 1));
            u_if.step      = SW'($urandom_range(0, 15));
            u_if.clr_flags = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0)
                u_if.limit = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 20)) : W'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0)
                u_if.mode = mode_e'($urandom_range(0, 1));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter core for the next-generation counter tile. It generalises the fixed 8-bit up/down counter with programmable width, step size and modulus limit, selectable wrap or saturate mode, synchronous load, a terminal-count pulse and sticky overflow/underflow flags. The core sits behind the tile's top-level I/O wrapper, which maps `ui_in`/`uio_in` onto its controls and `uo_out` onto `count`, instantiating it with WIDTH=8.

## Interface
- `WIDTH`, 8, counter and limit width in bits (≥2)
- `STEP_W`, 4, step input width in bits (1..WIDTH)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  count enable
- `up`  in  1  direction: 1 = up, 0 = down
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  WIDTH  load value
- `step`  in  STEP_W  increment/decrement magnitude
- `limit`  in  WIDTH  maximum count; range is 0..limit
- `mode`  in  1  0 = wrap (modulo limit+1), 1 = saturate
- `clr_flags`  in  1  clears `ovf`/`unf`
- `count`  out  WIDTH  current count, registered
- `tc`  out  1  terminal-count pulse, registered
- `ovf`  out  1  sticky overflow flag
- `unf`  out  1  sticky underflow flag

## Operation
- Priority per cycle: `rst` > `load` > `en`; otherwise hold, `tc`=0.
- Load: `count` ← min(`load_val`, `limit`); `tc`=0; flags unchanged.
- Effective step s = min(`step`, `limit`) (zero-extended to WIDTH+1). s = 0 → hold, no `tc`.
- Up, enabled: sum = count + s in WIDTH+1 bits. sum ≤ limit → count ← sum. sum > limit → wrap: count ← sum − (limit+1); saturate: count ← limit; `tc`=1, `ovf` set.
- Down, enabled: s ≤ count → count ← count − s. s > count → wrap: count ← count + limit + 1 − s; saturate: count ← 0; `tc`=1, `unf` set.
- Saturate mode at boundary: each further enabled step in the same direction re-asserts `tc` (one pulse per cycle) and keeps the flag set.
- Out-of-range (count > limit after `limit` reduced), enabled cycle with s > 0: count ← 0 (wrap) or limit (saturate), `tc`=1, `ovf` set, regardless of `up`. Not enabled: hold.
- `limit`=0: count stays 0, never `tc`.
- `clr_flags` clears `ovf`/`unf`; a set event in the same cycle wins.

## Timing
- All outputs registered; a control sampled at edge N is reflected in outputs after edge N.
- Reset values: `count`=0, `tc`=0, `ovf`=0, `unf`=0.
- `tc` is high exactly one cycle per boundary event.
- Reset asserted mid-count clears everything on the next edge; `load`/`en` ignored during reset.
- `limit`, `mode`, `step`, `up` may change every cycle; no pipelining.

## Structure
- Package `updown_counter_pkg`: `mode_e` enum (`MODE_WRAP`=0, `MODE_SAT`=1), defaults for WIDTH/STEP_W.
- Sub-module `updown_next_calc`: combinational next-count, `tc`, overflow/underflow event from count, s, limit, up, mode; top holds registers, priority and sticky flags.

## Test plan
- Reset, WIDTH=8, limit=255, up, step=1, en 300 cycles → count 0..255, wraps to 0 at cycle 256 with single `tc`, `ovf`=1.
- limit=9, wrap, up, step=3, from 0 → 3,6,9,2(`tc`),5; then down step=4 from 5 → 1,7(`tc`, `unf`=1).
- Saturate, limit=100, load 98, up step=5 → 100 with `tc`, next cycle 100 with `tc` again; down to 0 → holds 0, `tc` each cycle.
- load=1 and en=1 same cycle with load_val=200, limit=50 → count=50, `tc`=0.
- count=80, limit changed to 40, wrap, en, down → count=0, `tc`=1, `ovf`=1; `clr_flags` alone → flags 0; `clr_flags` with event → flag stays 1.
- rst asserted mid-count with load=1 → count=0, all flags 0 next edge; step=0 with en → hold, no `tc`.
